// File: rtl/playfield_settle.sv
// Settled-block playfield: locks a landed piece into the cell array, clears full rows
// bottom-up with gravity, counts cleared lines, flags game over and serves a colour read port.
module playfield_settle #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int CW   = 3,
   parameter int LW   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     step,
   input  logic [$clog2(COLS)-1:0]  x1,
   input  logic [$clog2(COLS)-1:0]  x2,
   input  logic [$clog2(COLS)-1:0]  x3,
   input  logic [$clog2(COLS)-1:0]  x4,
   input  logic [$clog2(ROWS)-1:0]  y1,
   input  logic [$clog2(ROWS)-1:0]  y2,
   input  logic [$clog2(ROWS)-1:0]  y3,
   input  logic [$clog2(ROWS)-1:0]  y4,
   input  logic [CW-1:0]            block_type,
   input  logic [$clog2(COLS)-1:0]  x_vga2,
   input  logic [$clog2(ROWS)-1:0]  y_vga2,
   output logic [11:0]              color,
   output logic                     block_logic_reset,
   output logic                     busy,
   output logic [LW-1:0]            lines_total,
   output logic                     game_over
);

   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOCK  = 3'd1,
      SCAN  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_r;
   state_t                            state_r;
   logic [YW-1:0]                     ptr_r;
   logic [3:0][XW-1:0]                cap_x_r;
   logic [3:0][YW-1:0]                cap_y_r;
   logic [CW-1:0]                     cap_type_r;
   logic                              blr_r;
   logic                              busy_r;
   logic                              game_over_r;
   logic [LW-1:0]                     lines_r;

   logic [3:0][XW-1:0]                xs_s;
   logic [3:0][YW-1:0]                ys_s;
   logic                              land_s;
   logic                              row_full_s;
   logic                              row0_occ_s;
   logic [11:0]                       color_s;

   assign xs_s = {x4, x3, x2, x1};
   assign ys_s = {y4, y3, y2, y1};

   function automatic logic in_field(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (int'(x) < COLS) && (int'(y) < ROWS);
   endfunction

   function automatic logic [11:0] palette(input logic [CW-1:0] idx);
      logic [11:0] rgb;
      case (idx)
         CW'(1):  rgb = 12'hF00;
         CW'(2):  rgb = 12'h0FF;
         CW'(3):  rgb = 12'hF0F;
         CW'(4):  rgb = 12'h0F8;
         CW'(5):  rgb = 12'h08F;
         CW'(6):  rgb = 12'h00F;
         CW'(7):  rgb = 12'hC00;
         default: rgb = 12'h000;
      endcase
      return rgb;
   endfunction

   // A piece lands if any in-field cell sits on the floor or on an occupied cell.
   always_comb begin
      land_s = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (in_field(xs_s[k], ys_s[k])) begin
            if (ys_s[k] == LAST_ROW) begin
               land_s = 1'b1;
            end else if (grid_r[ys_s[k] + YW'(1)][xs_s[k]] != '0) begin
               land_s = 1'b1;
            end else begin
               land_s = land_s;
            end
         end else begin
            land_s = land_s;
         end
      end
   end

   // Full-row test on the scan pointer and occupancy of the top row.
   always_comb begin
      row_full_s = 1'b1;
      row0_occ_s = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (grid_r[ptr_r][c] == '0) begin
            row_full_s = 1'b0;
         end else begin
            row_full_s = row_full_s;
         end
         if (grid_r[0][c] != '0) begin
            row0_occ_s = 1'b1;
         end else begin
            row0_occ_s = row0_occ_s;
         end
      end
   end

   // Display read port, combinational from the live array.
   always_comb begin
      if (in_field(x_vga2, y_vga2)) begin
         color_s = palette(grid_r[y_vga2][x_vga2]);
      end else begin
         color_s = 12'h000;
      end
   end

   // Lock / scan / shift / done sequencer with its registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid_r      <= '0;
         state_r     <= IDLE;
         ptr_r       <= '0;
         cap_x_r     <= '0;
         cap_y_r     <= '0;
         cap_type_r  <= '0;
         blr_r       <= 1'b0;
         busy_r      <= 1'b0;
         game_over_r <= 1'b0;
         lines_r     <= '0;
      end else begin
         blr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (step && !game_over_r && land_s) begin
                  cap_x_r    <= xs_s;
                  cap_y_r    <= ys_s;
                  cap_type_r <= block_type;
                  busy_r     <= 1'b1;
                  state_r    <= LOCK;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            LOCK: begin
               for (int k = 0; k < 4; k++) begin
                  if (in_field(cap_x_r[k], cap_y_r[k])) begin
                     grid_r[cap_y_r[k]][cap_x_r[k]] <= cap_type_r;
                  end
               end
               ptr_r   <= LAST_ROW;
               state_r <= SCAN;
            end
            SCAN: begin
               if (row_full_s) begin
                  state_r <= SHIFT;
               end else if (ptr_r == '0) begin
                  state_r <= DONE;
               end else begin
                  ptr_r   <= ptr_r - YW'(1);
                  state_r <= SCAN;
               end
            end
            SHIFT: begin
               // Rows at or above the pointer drop by one; the pointer stays to re-test.
               for (int r = ROWS - 1; r >= 1; r--) begin
                  if (r <= int'(ptr_r)) begin
                     grid_r[r] <= grid_r[r-1];
                  end
               end
               grid_r[0] <= '0;
               lines_r   <= lines_r + LW'(1);
               state_r   <= SCAN;
            end
            DONE: begin
               blr_r  <= 1'b1;
               busy_r <= 1'b0;
               if (row0_occ_s) begin
                  game_over_r <= 1'b1;
               end
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign color             = color_s;
   assign block_logic_reset = blr_r;
   assign busy              = busy_r;
   assign lines_total       = lines_r;
   assign game_over         = game_over_r;

endmodule

// File: doc/playfield_settle.md
PLAYFIELD_SETTLE -- requirements
Module: playfield_settle

Interface
REQ-001 Parameter COLS, default 10, playfield width in cells.
REQ-002 Parameter ROWS, default 20, playfield height in cells; row 0 is the top row.
REQ-003 Parameter CW, default 3, colour-index width; index 0 means an empty cell.
REQ-004 Parameter LW, default 16, width of the cleared-lines counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 step  input  1  gravity tick; requests a landing check of the active piece.
REQ-008 x1..x4  input  $clog2(COLS) each  column of each active-piece cell.
REQ-009 y1..y4  input  $clog2(ROWS) each  row of each active-piece cell.
REQ-010 block_type  input  CW  colour index of the active piece.
REQ-011 x_vga2, y_vga2  input  $clog2(COLS), $clog2(ROWS)  display read coordinates.
REQ-012 color  output  12  display colour of cell (x_vga2, y_vga2).
REQ-013 block_logic_reset  output  1  one-cycle pulse meaning the piece has settled and the next piece may spawn.
REQ-014 busy  output  1  high while a lock or line clear is in progress.
REQ-015 lines_total  output  LW  running count of cleared rows.
REQ-016 game_over  output  1  sticky flag meaning the stack has reached row 0.

Function
REQ-017 Storage SHALL be a ROWS x COLS array of CW-bit colour indices; a cell is occupied iff its index is non-zero.
REQ-018 Landing test SHALL be: for any cell k, yk == ROWS-1, or cell (yk+1, xk) is occupied.
REQ-019 Cells with xk >= COLS or yk >= ROWS SHALL be excluded from both the landing test and the write.
REQ-020 The FSM SHALL have the states IDLE, LOCK, SCAN, SHIFT and DONE.
REQ-021 IDLE: on step=1 with the landing test true, SHALL capture x1..x4, y1..y4 and block_type, then go to LOCK; otherwise SHALL stay in IDLE.
REQ-022 LOCK (1 cycle): SHALL write the captured block_type into all four captured cells, set the row pointer to ROWS-1, then go to SCAN.
REQ-023 SCAN (1 cycle per row): if every cell of the pointed row is occupied, SHALL go to SHIFT.
REQ-024 SCAN: otherwise, if the pointer is 0, SHALL go to DONE; else SHALL decrement the pointer and stay in SCAN.
REQ-025 SHIFT (1 cycle): every row r with 1 <= r <= pointer SHALL take the contents of row r-1, row 0 SHALL be cleared, and lines_total SHALL be incremented.
REQ-026 SHIFT: SHALL then return to SCAN with the pointer unchanged, so that the row shifted down is re-tested.
REQ-027 lines_total SHALL wrap modulo 2^LW.
REQ-028 DONE (1 cycle): SHALL assert block_logic_reset, set game_over if any cell of row 0 is occupied, then return to IDLE.
REQ-029 busy SHALL be 1 in LOCK, SCAN, SHIFT and DONE, and 0 in IDLE.
REQ-030 step SHALL be ignored while busy=1.
REQ-031 Latency with no full rows: block_logic_reset SHALL be high exactly ROWS+2 cycles after the sampling edge of step.
REQ-032 Latency with n cleared rows: block_logic_reset SHALL be high exactly ROWS+2+2n cycles after that edge.
REQ-033 Once game_over=1, the block SHALL treat step as 0 until reset.
REQ-034 color SHALL be combinational from (x_vga2, y_vga2), mapping index 1 blue 12'hF00, 2 yellow 12'h0FF, 3 magenta 12'hF0F, 4 green 12'h0F8, 5 orange 12'h08F, 6 red 12'h00F, 7 light blue 12'hC00.
REQ-035 color SHALL be 12'h000 for index 0, for indices above 7, and for out-of-range read coordinates.
REQ-036 The display read port SHALL reflect array updates from the cycle after each write, with no read stalls.

Reset
REQ-037 On reset=0, SHALL asynchronously clear all cells to 0, state to IDLE, and the pointer to 0.
REQ-038 On reset=0, SHALL clear block_logic_reset, busy, lines_total and game_over to 0.
REQ-039 Reset asserted mid-lock or mid-clear SHALL abandon the operation immediately, with no partial pulse of block_logic_reset.

Verification
REQ-040 Empty field; piece at rows 19 (x=3..6), step=1 -> row 19 cols 3..6 = type 1; block_logic_reset pulse 22 cycles later; color at (3,19) = 12'hF00.
REQ-041 Piece at row 5 over an empty column, step=1 -> no state change, busy stays 0, no pulse.
REQ-042 Row 19 holds cols 0..5; type-2 piece lands filling cols 6..9 -> row 19 cleared, rows shifted down, lines_total=1, pulse at cycle 24.
REQ-043 Rows 18 and 19 each one cell short; vertical piece completes both -> lines_total=2, pulse at cycle 26, rows 18..19 reflect the former rows 16..17.
REQ-044 step pulsed during SCAN -> ignored; exactly one block_logic_reset pulse.
REQ-045 Stack a column up to row 0 -> game_over=1 at DONE; later step pulses ignored; reset=0 mid-SCAN -> all outputs 0 immediately.
